// File: rtl/dt_sti_loader.sv
// dt_sti_loader: packs a serial binary-image pixel stream into sti memory words, then starts the DT engine and waits for done.
module dt_sti_loader #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int WORD_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic              pix_data,
  input  logic              pix_last,
  output logic              sti_wr,
  output logic [ADDR_W-1:0] sti_waddr,
  output logic [WORD_W-1:0] sti_do,
  output logic              dt_start,
  input  logic              dt_done,
  output logic              busy,
  output logic              border_err,
  output logic              frame_err
);
  localparam int CW = $clog2(IMG_W * IMG_H);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = CW - XW;
  localparam int BW = $clog2(WORD_W);
  typedef enum logic [2:0] {IDLE, ACCUM, WRITE, ZFILL, START, WAIT} state_t;
  state_t state;
  logic [CW-1:0] pix_cnt;
  logic [WORD_W-1:0] shreg;
  logic early;
  logic take, on_border, last_word, final_pix;
  logic [XW-1:0] col;
  logic [YW-1:0] row;
  logic [BW-1:0] bit_pos;
  logic [WORD_W-1:0] packed_word;
  // Held low during reset so every output reads 0 while reset is asserted.
  assign pix_ready = reset && (state == IDLE || state == ACCUM);
  assign take = pix_valid && pix_ready;
  assign col = pix_cnt[XW-1:0];
  assign row = pix_cnt[CW-1:XW];
  assign bit_pos = pix_cnt[BW-1:0];
  assign on_border = row == '0 || row == '1 || col == '0 || col == '1;
  assign last_word = &bit_pos;
  assign final_pix = &pix_cnt;
  assign packed_word = shreg | (WORD_W'(pix_data) << bit_pos);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pix_cnt    <= '0;
      shreg      <= '0;
      early      <= 1'b0;
      sti_wr     <= 1'b0;
      sti_waddr  <= '0;
      sti_do     <= '0;
      dt_start   <= 1'b0;
      busy       <= 1'b0;
      border_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: if (take) begin
          busy       <= 1'b1;
          pix_cnt    <= pix_cnt + 1'b1;
          border_err <= (state == ACCUM && border_err) || (pix_data && on_border);
          frame_err  <= (state == ACCUM && frame_err) || (pix_last != final_pix);
          early      <= pix_last && !final_pix;
          if (last_word || pix_last) begin
            sti_wr    <= 1'b1;
            sti_waddr <= ADDR_W'(pix_cnt >> BW);
            sti_do    <= packed_word;
            state     <= WRITE;
          end else begin
            shreg <= packed_word;
            state <= ACCUM;
          end
        end
        WRITE: begin
          shreg <= '0;
          if (&sti_waddr) begin
            sti_wr   <= 1'b0;
            dt_start <= 1'b1;
            state    <= START;
          end else if (early) begin
            sti_waddr <= sti_waddr + 1'b1;
            sti_do    <= '0;
            state     <= ZFILL;
          end else begin
            sti_wr <= 1'b0;
            state  <= ACCUM;
          end
        end
        ZFILL: if (&sti_waddr) begin
          sti_wr   <= 1'b0;
          dt_start <= 1'b1;
          state    <= START;
        end else sti_waddr <= sti_waddr + 1'b1;
        START: begin
          dt_start <= 1'b0;
          state    <= WAIT;
        end
        WAIT: if (dt_done) begin
          busy    <= 1'b0;
          pix_cnt <= '0;
          early   <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dt_sti_loader.sv
// tb_dt_sti_loader: scoreboard bench for dt_sti_loader; expected sti words are queued as frames are driven.
module tb_dt_sti_loader;
  logic clk = 1'b0;
  logic reset, pix_valid, pix_data, pix_last, dt_done;
  logic pix_ready, sti_wr, dt_start, busy, border_err, frame_err;
  logic [9:0] sti_waddr;
  logic [15:0] sti_do;
  bit pix [16384];
  logic [25:0] q [$];
  logic [15:0] mem [1024];
  int n_checks = 0, n_fail = 0;
  int wr_cnt = 0, ds_cnt = 0, cyc = 0, t7 = 0, t1023 = 0;
  int wr_base, ds_base;

  dt_sti_loader dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_last(pix_last), .sti_wr(sti_wr), .sti_waddr(sti_waddr),
    .sti_do(sti_do), .dt_start(dt_start), .dt_done(dt_done), .busy(busy),
    .border_err(border_err), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && sti_wr) begin
      wr_cnt++;
      mem[sti_waddr] = sti_do;
      if (sti_waddr == 10'd7) t7 = cyc;
      if (sti_waddr == 10'd1023) t1023 = cyc;
      if (q.size() == 0) check("sti_extra_write", 1, 0);
      else begin
        logic [25:0] e;
        e = q.pop_front();
        check("sti_waddr", 32'(sti_waddr), 32'(e[25:16]));
        check("sti_do", 32'(sti_do), 32'(e[15:0]));
      end
    end
    if (reset && dt_start) ds_cnt++;
  end

  task automatic push_expected(input int nwords, input int last_idx);
    for (int w = 0; w < nwords; w++) begin
      logic [15:0] d;
      logic [9:0] a;
      d = '0;
      a = 10'(w);
      for (int b = 0; b < 16; b++)
        if (last_idx < 0 || w * 16 + b <= last_idx) d[b] = pix[w * 16 + b];
      q.push_back({a, d});
    end
  endtask

  task automatic begin_frame();
    wr_base = wr_cnt;
    ds_base = ds_cnt;
  endtask

  task automatic drive(input int n, input int last_idx, input int gap_pct, input int probe);
    for (int p = 0; p < n; p++) begin
      int guard;
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        pix_valid = 1'b0;
        repeat ($urandom_range(3, 1)) begin @(posedge clk); #1; end
      end
      pix_valid = 1'b1;
      pix_data = pix[p];
      pix_last = (p == last_idx);
      guard = 0;
      while (!pix_ready && guard < 100) begin @(posedge clk); #1; guard++; end
      if (guard >= 100) begin
        check("ready_timeout", 0, 1);
        break;
      end
      @(posedge clk); #1;
      if (p == probe) check("border_after_pix", border_err, 1);
    end
    pix_valid = 1'b0;
    pix_last = 1'b0;
  endtask

  task automatic finish_frame(input int hold);
    int n = 0, bad = 0;
    while (!dt_start && n < 3000) begin @(posedge clk); #1; n++; end
    check("dt_start_seen", dt_start, 1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!busy || pix_ready) bad++;
    end
    check("wait_hold", bad, 0);
    dt_done = 1'b1;
    @(posedge clk); #1;
    dt_done = 1'b0;
    check("busy_cleared", busy, 0);
    check("ready_after_done", pix_ready, 1);
    repeat (2) begin @(posedge clk); #1; end
    check("wr_count", wr_cnt - wr_base, 1024);
    check("dt_start_pulses", ds_cnt - ds_base, 1);
    check("queue_empty", q.size(), 0);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; pix_valid = 1'b0; pix_data = 1'b0; pix_last = 1'b0; dt_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {sti_wr, sti_waddr, sti_do, dt_start, busy}, 0);
    check("rst_flags", {border_err, frame_err, pix_ready}, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("idle_ready", pix_ready, 1);

    // checkerboard with clear border, continuous valid
    for (int p = 0; p < 16384; p++) begin
      int r, c;
      r = p / 128; c = p % 128;
      pix[p] = (p % 2 == 0) && !(r == 0 || r == 127 || c == 0 || c == 127);
    end
    begin_frame();
    push_expected(1024, 16383);
    drive(16384, 16383, 0, -1);
    finish_frame(3);
    check("cb_word8", mem[8], 16'h5554);
    check("cb_border_err", border_err, 0);
    check("cb_frame_err", frame_err, 0);

    // early pix_last on p=99
    for (int p = 0; p < 16384; p++) pix[p] = 1'($urandom_range(1));
    begin_frame();
    push_expected(1024, 99);
    drive(100, 99, 0, -1);
    finish_frame(3);
    check("early_frame_err", frame_err, 1);
    check("early_word6_hi", 32'(mem[6][15:4]), 0);
    check("zfill_consecutive", t1023 - t7, 1016);

    // border object at row 0 col 5, random gaps, long dt_done wait
    for (int p = 0; p < 16384; p++) pix[p] = 1'b0;
    pix[5] = 1'b1;
    begin_frame();
    push_expected(1024, 16383);
    drive(16384, 16383, 20, 5);
    finish_frame(500);
    check("border_err_kept", border_err, 1);
    check("border_frame_err", frame_err, 0);

    // reset while accumulating at pixel 5000
    for (int p = 0; p < 16384; p++) pix[p] = 1'($urandom_range(1));
    begin_frame();
    push_expected(312, -1);
    drive(5000, -1, 0, -1);
    check("pre_reset_busy", busy, 1);
    reset = 1'b0;
    #1;
    check("midrst_outputs", {sti_wr, sti_waddr, sti_do, dt_start, busy}, 0);
    check("midrst_flags", {border_err, frame_err, pix_ready}, 0);
    check("midrst_queue", q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    check("no_write_after_reset", wr_cnt - wr_base, 312);
    check("ready_after_reset", pix_ready, 1);

    // single object pixel at row 1 col 17, pix_last never asserted
    for (int p = 0; p < 16384; p++) pix[p] = 1'b0;
    pix[145] = 1'b1;
    begin_frame();
    push_expected(1024, 16383);
    drive(16384, -1, 0, -1);
    finish_frame(3);
    check("single_word9", mem[9], 16'h0002);
    check("single_border_err", border_err, 0);
    check("missing_last_frame_err", frame_err, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
